// File: rtl/debounce_scan_ctrl_pkg.sv
// Shared definitions for the time-multiplexed debounce controller:
// sweep FSM state encodings and the channel-index width helper.
package debounce_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Width of the channel index; a single channel still gets a 1-bit index
    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/debounce_scan_ctrl_sync_2ff.sv
// Two-flop synchronizer bank for the raw asynchronous panel inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to resolve
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debouncer: one shared history-update datapath swept
// round-robin across all channels once per prescaler tick.
module debounce_scan_ctrl
    import debounce_scan_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int HIST_LEN = 8,
    parameter int TICK_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] buttons,
    output logic [NUM_CH-1:0] debounced,
    output logic [NUM_CH-1:0] changed,
    output logic              scan_active,
    output logic              sweep_done
);

    localparam int IDX_W = idx_width(NUM_CH);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);

    // A sweep plus its DONE cycle must fit between ticks, or sweeps would overlap
    if (TICK_DIV < NUM_CH + 2) begin : g_bad_tick_div
        $error("debounce_scan_ctrl: TICK_DIV must be >= NUM_CH+2");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("debounce_scan_ctrl: NUM_CH must be in 1..16");
    end
    if (HIST_LEN < 2 || HIST_LEN > 16) begin : g_bad_hist_len
        $error("debounce_scan_ctrl: HIST_LEN must be in 2..16");
    end

    logic [NUM_CH-1:0]   sync_in;
    logic [CNT_W-1:0]    presc_q;
    logic                tick;
    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HIST_LEN-1:0] hist_q [NUM_CH];
    logic [HIST_LEN-1:0] hist_d [NUM_CH];
    logic [HIST_LEN-1:0] hist_new;
    logic [NUM_CH-1:0]   deb_d;
    logic [NUM_CH-1:0]   chg_d;

    sync_2ff #(
        .WIDTH (NUM_CH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (buttons),
        .q     (sync_in)
    );

    assign tick = enable && (presc_q == CNT_MAX);

    // Sample-tick prescaler; parked at zero while disabled so a re-enable waits a full period
    always_ff @(posedge clk) begin
        if (reset || !enable || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + CNT_W'(1);
        end
    end

    // Sweep sequencing and the shared shift-and-qualify step for the selected channel
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hist_d      = hist_q;
        deb_d       = debounced;
        chg_d       = '0;
        scan_active = 1'b0;
        sweep_done  = 1'b0;
        hist_new    = {hist_q[idx_q][HIST_LEN-2:0], sync_in[idx_q]};
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                scan_active    = 1'b1;
                hist_d[idx_q]  = hist_new;
                if ((&hist_new) && !debounced[idx_q]) begin
                    deb_d[idx_q] = 1'b1;
                    chg_d[idx_q] = 1'b1;
                end else if (!(|hist_new) && debounced[idx_q]) begin
                    deb_d[idx_q] = 1'b0;
                    chg_d[idx_q] = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index, histories and debounced levels; reset clears debounced without a changed pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            debounced <= '0;
            changed   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            debounced <= deb_d;
            changed   <= chg_d;
            hist_q    <= hist_d;
        end
    end

    // Tick spacing guarantees a tick only ever lands while idle
    a_tick_only_in_idle: assert property (@(posedge clk) disable iff (reset) tick |-> state_q == IDLE);

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed self-checking bench for debounce_scan_ctrl with default parameters
// (NUM_CH=4, HIST_LEN=8, TICK_DIV=16).
module tb_debounce_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] buttons;
    logic [3:0] debounced;
    logic [3:0] changed;
    logic       scan_active;
    logic       sweep_done;

    int total = 0;
    int bad   = 0;
    int pulse_cnt [4] = '{0, 0, 0, 0};
    logic multi_hot = 1'b0;

    debounce_scan_ctrl #(
        .NUM_CH   (4),
        .HIST_LEN (8),
        .TICK_DIV (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .buttons     (buttons),
        .debounced   (debounced),
        .changed     (changed),
        .scan_active (scan_active),
        .sweep_done  (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally changed pulses per channel and catch more than one bit high at once
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (changed[k] === 1'b1) pulse_cnt[k]++;
        end
        if (!$isunknown(changed) && $countones(changed) > 1) multi_hot = 1'b1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic rst, input logic en, input logic [3:0] btn);
        reset   = rst;
        enable  = en;
        buttons = btn;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_deb(input int ch, input logic val, input int limit, output int elapsed);
        elapsed = 0;
        while (debounced[ch] !== val && elapsed < limit) begin
            step(1);
            elapsed++;
        end
    endtask

    task automatic wait_scan_start(input string tag);
        int n = 0;
        while (scan_active !== 1'b0 && n < 40) begin
            step(1);
            n++;
        end
        while (scan_active !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check_output(tag, 32'(scan_active), 32'd1);
    endtask

    initial begin
        logic [9:0] acc;
        logic [3:0] btn;
        int sa;
        int sd;
        int elapsed;

        // Reset, then inputs high but disabled: nothing may move
        apply_stimulus(1'b1, 1'b0, 4'b0000);
        step(3);
        check_output("rst_debounced", 32'(debounced), 32'd0);
        check_output("rst_changed", 32'(changed), 32'd0);
        check_output("rst_scan_active", 32'(scan_active), 32'd0);
        check_output("rst_sweep_done", 32'(sweep_done), 32'd0);
        apply_stimulus(1'b0, 1'b0, 4'b1111);
        acc = '0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            acc |= {debounced, changed, scan_active, sweep_done};
        end
        check_output("t1_disabled_quiet", 32'(acc), 32'd0);

        // Channel 2 held high from enable: rises exactly on sweep 8, SCAN cycle 2
        apply_stimulus(1'b0, 1'b0, 4'b0100);
        step(3);
        apply_stimulus(1'b0, 1'b1, 4'b0100);
        step(15);
        check_output("t2_idle_before_tick", 32'(scan_active), 32'd0);
        step(1);
        check_output("t2_first_scan", 32'(scan_active), 32'd1);
        sa = 0;
        sd = 0;
        for (int i = 0; i < 16; i++) begin
            sa += int'(scan_active);
            sd += int'(sweep_done);
            step(1);
        end
        check_output("t2_scan_cycles_per_period", 32'(sa), 32'd4);
        check_output("t2_done_pulses_per_period", 32'(sd), 32'd1);
        step(98);
        check_output("t2_not_yet_sweep8", 32'(debounced), 32'd0);
        step(1);
        check_output("t2_rise_debounced", 32'(debounced), 32'b0100);
        check_output("t2_rise_changed", 32'(changed), 32'b0100);
        check_output("t2_rise_in_scan", 32'(scan_active), 32'd1);
        step(1);
        check_output("t2_changed_one_cycle", 32'(changed), 32'd0);
        check_output("t2_debounced_held", 32'(debounced), 32'b0100);

        // Channel 0 chatters with period 10: never qualifies, then a steady 1 does
        btn = 4'b0100;
        for (int i = 0; i < 60; i++) begin
            btn[0] = ~btn[0];
            apply_stimulus(1'b0, 1'b1, btn);
            step(5);
        end
        apply_stimulus(1'b0, 1'b1, 4'b0100);
        step(20);
        check_output("t3_chatter_no_rise", 32'(debounced), 32'b0100);
        check_output("t3_chatter_no_pulse", 32'(pulse_cnt[0]), 32'd0);
        apply_stimulus(1'b0, 1'b1, 4'b0101);
        wait_deb(0, 1'b1, 160, elapsed);
        check_output("t3_hold_rise", 32'(debounced[0]), 32'd1);
        check_output("t3_latency_in_range", 32'(elapsed >= 112 && elapsed <= 150), 32'd1);

        // Channel 1 qualified high, then dropped with one injected high sample midway
        apply_stimulus(1'b0, 1'b1, 4'b0111);
        wait_deb(1, 1'b1, 160, elapsed);
        check_output("t4_setup_rise", 32'(debounced), 32'b0111);
        apply_stimulus(1'b0, 1'b1, 4'b0101);
        step(64);
        apply_stimulus(1'b0, 1'b1, 4'b0111);
        step(16);
        check_output("t4_still_high_at_glitch", 32'(debounced[1]), 32'd1);
        apply_stimulus(1'b0, 1'b1, 4'b0101);
        wait_deb(1, 1'b0, 200, elapsed);
        check_output("t4_fall", 32'(debounced), 32'b0101);
        check_output("t4_restarted_latency", 32'(elapsed >= 112 && elapsed <= 150), 32'd1);

        // Disable during SCAN idx 1: sweep finishes with one DONE, then stays idle
        wait_scan_start("t5_scan_start");
        step(1);
        check_output("t5_in_scan_idx1", 32'(scan_active), 32'd1);
        apply_stimulus(1'b0, 1'b0, 4'b0101);
        sa = 0;
        sd = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            sa += int'(scan_active);
            sd += int'(sweep_done);
        end
        check_output("t5_remaining_scan_cycles", 32'(sa), 32'd2);
        check_output("t5_single_done", 32'(sd), 32'd1);
        check_output("t5_debounced_retained", 32'(debounced), 32'b0101);

        // Reach 1010, reset during SCAN idx 2, then full re-qualification
        apply_stimulus(1'b0, 1'b1, 4'b1010);
        elapsed = 0;
        while (debounced !== 4'b1010 && elapsed < 250) begin
            step(1);
            elapsed++;
        end
        check_output("t6_setup_1010", 32'(debounced), 32'b1010);
        wait_scan_start("t6_scan_start");
        step(2);
        check_output("t6_in_scan_idx2", 32'(scan_active), 32'd1);
        apply_stimulus(1'b1, 1'b1, 4'b1010);
        step(1);
        check_output("t6_rst_debounced", 32'(debounced), 32'd0);
        check_output("t6_rst_changed", 32'(changed), 32'd0);
        check_output("t6_rst_idle", 32'({scan_active, sweep_done}), 32'd0);
        apply_stimulus(1'b0, 1'b1, 4'b1010);
        step(129);
        check_output("t6_not_yet_requalified", 32'(debounced), 32'd0);
        step(1);
        check_output("t6_ch1_requalified", 32'(debounced), 32'b0010);
        check_output("t6_ch1_pulse", 32'(changed), 32'b0010);
        step(2);
        check_output("t6_ch3_requalified", 32'(debounced), 32'b1010);
        check_output("t6_ch3_pulse", 32'(changed), 32'b1000);
        step(2);

        check_output("pulses_ch0", 32'(pulse_cnt[0]), 32'd2);
        check_output("pulses_ch1", 32'(pulse_cnt[1]), 32'd4);
        check_output("pulses_ch2", 32'(pulse_cnt[2]), 32'd2);
        check_output("pulses_ch3", 32'(pulse_cnt[3]), 32'd2);
        check_output("changed_onehot", 32'(multi_hot), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
